// File: rtl/serial_operand_shifter.sv
// Parallel-to-serial operand feeder for an external 1-bit serial adder.
// It streams operand A and B LSB first, collects the returned sum bits and presents the assembled word.
module serial_operand_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_bit,
  output logic             b_bit,
  output logic             carry_clr,
  input  logic             sum_bit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on state; res_valid/res_sum stay stable until res_ready is seen.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    carry_clr = 1'b1;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        carry_clr     = 1'b0;
        a_bit         = a_q[0];
        b_bit         = b_q[0];
        acc_d[cnt_q]  = sum_bit;
        a_d           = a_q >> 1;
        b_d           = b_q >> 1;
        // Sum bits build up in acc so res_sum only changes when a whole word is ready.
        if (cnt_q == LAST) begin
          res_d   = acc_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign res_sum   = res_q;
  assign dbg_state = state_q;

endmodule

// File: doc/serial_operand_shifter.md
SERIAL_OPERAND_SHIFTER -- requirements
Module: serial_operand_shifter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  parallel operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 a_bit  output  1  serial operand A bit, LSB first, to the downstream 1-bit serial adder.
REQ-009 b_bit  output  1  serial operand B bit, LSB first.
REQ-010 carry_clr  output  1  drives the serial adder's synchronous carry clear.
REQ-011 sum_bit  input  1  combinational sum bit returned by the serial adder for the current a_bit/b_bit.
REQ-012 res_valid  output  1  result word available.
REQ-013 res_ready  input  1  consumer accepts result.
REQ-014 res_sum  output  WIDTH  assembled sum, (in_a + in_b) mod 2^WIDTH.

Function
REQ-015 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1 (accept, cycle T) the block SHALL latch in_a/in_b into shift registers, clear the bit counter, and go to SHIFT.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid in SHIFT/DONE SHALL be ignored, with in_a/in_b not sampled.
REQ-018 SHIFT: in cycle T+1+i (i = 0..WIDTH-1), a_bit/b_bit SHALL equal bit i of the latched in_a/in_b.
REQ-019 In SHIFT, each cycle the block SHALL sample sum_bit into bit i of the result register, then shift operands right and increment the counter.
REQ-020 When the counter reaches WIDTH-1 and that bit is captured, the FSM SHALL go to DONE (cycle T+WIDTH+1).
REQ-021 carry_clr SHALL be 1 in every state except SHIFT, so the downstream carry is 0 during bit 0 of every word.
REQ-022 carry_clr SHALL be 0 throughout SHIFT so carry propagates between bits.
REQ-023 a_bit and b_bit SHALL be 0 outside SHIFT.
REQ-024 DONE: res_valid=1 and res_sum SHALL hold stable until res_ready=1; res_valid SHALL first assert at T+WIDTH+1.
REQ-025 In DONE with res_ready=1, the FSM SHALL go to IDLE next cycle; the next accept is possible no earlier than T+WIDTH+2.
REQ-026 Carry out of bit WIDTH-1 SHALL be discarded; no overflow output exists.
REQ-027 res_valid SHALL be 0 in IDLE and SHIFT; res_sum SHALL retain its last value outside DONE.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-029 While rst=1, regardless of clk: state=IDLE; counter, operand and result registers=0.
REQ-030 While rst=1, outputs SHALL be: in_ready=1, res_valid=0, res_sum=0, a_bit=b_bit=0, carry_clr=1.
REQ-031 rst asserted mid-SHIFT or in DONE SHALL abort the word with no result produced; operation after release SHALL start from IDLE.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 WIDTH=8, in_a=0x5A, in_b=0x33, res_ready=1 -> a_bit stream 0,1,0,1,1,0,1,0 over T+1..T+8; res_valid at T+9; res_sum=0x8D.
REQ-034 in_a=0xFF, in_b=0x01 -> res_sum=0x00; carry_clr low exactly T+1..T+8.
REQ-035 Backpressure: res_ready=0 for 5 cycles after DONE -> res_valid and res_sum=0x8D held; in_ready=0 and a new in_valid ignored until one cycle after res_ready=1.
REQ-036 Reset mid-word: rst pulsed at T+4 -> res_valid never asserts for that word; next word 0x01+0x02 yields res_sum=0x03.
REQ-037 Back-to-back: in_valid and res_ready held high with 256 random pairs -> every res_sum matches (a+b) mod 256; one accept per WIDTH+2 cycles.
REQ-038 WIDTH=2, in_a=0x3, in_b=0x3 -> res_sum=0x2 at T+3.
